// File: rtl/chacha_host_driver.sv
// Host-side sequencer for a pin-level ChaCha core: loads key/ctr/nonce byte-serially,
// starts a block, then relays the 64 keystream bytes out over a valid/ready stream.
module chacha_host_driver #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [255:0] req_key,
    input  logic [31:0]  req_ctr,
    input  logic [95:0]  req_nonce,
    output logic [7:0]   ks_data,
    output logic         ks_valid,
    input  logic         ks_ready,
    output logic         ks_last,
    output logic         err,
    output logic [7:0]   pin_ui,
    output logic [7:0]   pin_uio,
    input  logic [7:0]   core_uo,
    input  logic [7:0]   core_uio
);

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        READ,
        ACK
    } state_t;

    state_t         state_q;
    logic [383:0]   load_sr_q;
    logic [5:0]     load_cnt_q;
    logic [6:0]     byte_cnt_q;
    logic [WW-1:0]  wait_cnt_q;
    logic [7:0]     pin_ui_q;
    logic [7:0]     pin_uio_q;
    logic [7:0]     ks_data_q;
    logic           ks_valid_q;
    logic           ks_last_q;
    logic           err_q;

    logic core_done;
    logic core_out_vld;
    logic unused_core_uio;

    assign core_done       = core_uio[0];
    assign core_out_vld    = core_uio[1];
    assign unused_core_uio = ^core_uio[7:2];

    assign req_ready = (state_q == IDLE);
    assign pin_ui    = pin_ui_q;
    assign pin_uio   = pin_uio_q;
    assign ks_data   = ks_data_q;
    assign ks_valid  = ks_valid_q;
    assign ks_last   = ks_last_q;
    assign err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            load_sr_q  <= '0;
            load_cnt_q <= '0;
            byte_cnt_q <= '0;
            wait_cnt_q <= '0;
            pin_ui_q   <= '0;
            pin_uio_q  <= '0;
            ks_data_q  <= '0;
            ks_valid_q <= 1'b0;
            ks_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pin_ui_q   <= '0;
                    pin_uio_q  <= '0;
                    byte_cnt_q <= '0;
                    if (req_valid) begin
                        // Byte 0 goes out on entry to LOAD; the shifter holds the remaining 47.
                        load_sr_q  <= {req_nonce, req_ctr, req_key} >> 8;
                        pin_ui_q   <= req_key[7:0];
                        pin_uio_q  <= 8'h01;
                        load_cnt_q <= 6'd1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_cnt_q == 6'd48) begin
                        pin_ui_q   <= '0;
                        pin_uio_q  <= 8'h02;
                        load_cnt_q <= '0;
                        state_q    <= START;
                    end else begin
                        pin_ui_q   <= load_sr_q[7:0];
                        load_sr_q  <= load_sr_q >> 8;
                        load_cnt_q <= load_cnt_q + 6'd1;
                    end
                end
                START: begin
                    pin_uio_q  <= '0;
                    wait_cnt_q <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        state_q <= READ;
                    end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                READ: begin
                    if (ks_valid_q) begin
                        if (ks_ready) begin
                            ks_valid_q <= 1'b0;
                            ks_last_q  <= 1'b0;
                            byte_cnt_q <= byte_cnt_q + 7'd1;
                            pin_uio_q  <= 8'h04;
                            state_q    <= ACK;
                        end
                    end else if (core_out_vld) begin
                        ks_data_q  <= core_uo;
                        ks_valid_q <= 1'b1;
                        ks_last_q  <= (byte_cnt_q == 7'd63);
                    end
                end
                ACK: begin
                    pin_uio_q <= '0;
                    if (byte_cnt_q == 7'd64) begin
                        byte_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        state_q <= READ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_host_driver.sv
// Directed bench for chacha_host_driver with a behavioural pin-level core model.
module tb_chacha_host_driver;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [255:0] req_key = '0;
    logic [31:0]  req_ctr = '0;
    logic [95:0]  req_nonce = '0;
    logic [7:0]   ks_data;
    logic         ks_valid;
    logic         ks_ready = 1'b1;
    logic         ks_last;
    logic         err;
    logic [7:0]   pin_ui;
    logic [7:0]   pin_uio;
    logic [7:0]   core_uo;
    logic [7:0]   core_uio;

    int n_chk  = 0;
    int n_fail = 0;

    // core model controls and state
    logic ovr = 1'b0;
    logic done_en = 1'b1;
    logic m_run, m_done, m_rd;
    int   m_cnt, m_idx;

    // stream monitor
    logic [7:0] out_buf [0:511];
    logic       last_buf[0:511];
    int out_n = 0;
    int ack_cnt = 0;
    int multi = 0;

    chacha_host_driver #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_ctr(req_ctr), .req_nonce(req_nonce),
        .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_last(ks_last),
        .err(err), .pin_ui(pin_ui), .pin_uio(pin_uio),
        .core_uo(core_uo), .core_uio(core_uio)
    );

    always #5 clk = ~clk;

    assign core_uio = ovr ? 8'h03 : {6'b0, m_rd && (m_idx < 64), m_done};
    assign core_uo  = 8'h80 + 8'(m_idx);

    // Core: done pulse ~10 cycles after start, then bytes 0x80.. advanced by each ack.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0; m_done <= 1'b0; m_rd <= 1'b0; m_cnt <= 0; m_idx <= 0;
        end else begin
            m_done <= 1'b0;
            if (pin_uio[1]) begin
                m_run <= 1'b1; m_cnt <= 1; m_rd <= 1'b0; m_idx <= 0;
            end else if (m_run) begin
                if (m_cnt == 9) begin
                    m_run <= 1'b0; m_done <= done_en; m_rd <= done_en;
                end
                m_cnt <= m_cnt + 1;
            end
            if (pin_uio[2] && m_idx < 64) m_idx <= m_idx + 1;
        end
    end

    always @(posedge clk) begin
        if (ks_valid && ks_ready) begin
            out_buf[out_n]  <= ks_data;
            last_buf[out_n] <= ks_last;
            out_n <= out_n + 1;
        end
        if (pin_uio[2]) ack_cnt <= ack_cnt + 1;
        if ($countones(pin_uio[2:0]) > 1) multi <= multi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n);
        @(negedge clk);
        req_key = k; req_ctr = c; req_nonce = n; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input string tag);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (out_n - base == 64 && req_ready) break;
        end
        chk({tag, "_count"}, 32'(out_n - base), 32'd64);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic check_stream(input int base, input string tag);
        int bad_d = 0;
        int bad_l = 0;
        for (int i = 0; i < 64; i++) begin
            if (out_buf[base + i] !== 8'(8'h80 + i)) bad_d++;
            if (last_buf[base + i] !== (i == 63)) bad_l++;
        end
        chk({tag, "_data_errs"}, 32'(bad_d), 32'd0);
        chk({tag, "_last_errs"}, 32'(bad_l), 32'd0);
        chk({tag, "_first"}, {24'b0, out_buf[base]}, 32'h80);
        chk({tag, "_final"}, {24'b0, out_buf[base + 63]}, 32'hBF);
    endtask

    logic [255:0] key_a, key_b;
    logic [95:0]  nonce_a;
    logic [7:0]   exp_load[48];
    int base, ack0, bad, seen;

    initial begin
        for (int i = 0; i < 32; i++) key_a[8*i +: 8] = 8'(i);
        for (int i = 0; i < 32; i++) key_b[8*i +: 8] = 8'(8'hA0 + i);
        for (int i = 0; i < 12; i++) nonce_a[8*i +: 8] = 8'(i);
        for (int i = 0; i < 32; i++) exp_load[i] = 8'(i);
        exp_load[32] = 8'h01; exp_load[33] = 8'h00; exp_load[34] = 8'h00; exp_load[35] = 8'h00;
        for (int i = 0; i < 12; i++) exp_load[36 + i] = 8'(i);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_pin_ui", {24'b0, pin_ui}, 32'd0);
        chk("rst_pin_uio", {24'b0, pin_uio}, 32'd0);
        chk("rst_ks_valid", {31'b0, ks_valid}, 32'd0);
        chk("rst_ks_last", {31'b0, ks_last}, 32'd0);
        chk("rst_ks_data", {24'b0, ks_data}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;

        // done/out-valid held high in IDLE must change nothing
        ovr = 1'b1;
        repeat (5) @(negedge clk);
        chk("ovr_idle_ready", {31'b0, req_ready}, 32'd1);
        chk("ovr_idle_uio", {24'b0, pin_uio}, 32'd0);
        chk("ovr_idle_valid", {31'b0, ks_valid}, 32'd0);

        // job 1: load sequence, then full stream
        base = out_n; ack0 = ack_cnt;
        start_job(key_a, 32'h1, nonce_a);
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            chk($sformatf("load_ui_%0d", i), {24'b0, pin_ui}, {24'b0, exp_load[i]});
            if (pin_uio !== 8'h01 || req_ready !== 1'b0 || ks_valid !== 1'b0) bad++;
            if (i == 47) ovr = 1'b0;
            @(negedge clk);
        end
        chk("load_uio_ready_valid_errs", 32'(bad), 32'd0);
        chk("start_uio", {24'b0, pin_uio}, 32'h02);
        chk("start_ui", {24'b0, pin_ui}, 32'h00);
        @(negedge clk);
        chk("wait_uio", {24'b0, pin_uio}, 32'h00);
        wait_done(base, "job1");
        check_stream(base, "job1");
        chk("job1_acks", 32'(ack_cnt - ack0), 32'd64);

        // job 2: stall 20 cycles on byte 0x85
        base = out_n; ack0 = ack_cnt;
        start_job(key_a, 32'h1, nonce_a);
        seen = 0;
        for (int k = 0; k < 500; k++) begin
            if (ks_valid && ks_data == 8'h85) begin seen = 1; break; end
            @(negedge clk);
        end
        chk("bp_reach_85", 32'(seen), 32'd1);
        ks_ready = 1'b0;
        ack0 = ack_cnt;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ks_valid !== 1'b1 || ks_data !== 8'h85 || pin_uio !== 8'h00) bad++;
        end
        chk("bp_stable_errs", 32'(bad), 32'd0);
        chk("bp_no_ack", 32'(ack_cnt - ack0), 32'd0);
        chk("bp_delivered", 32'(out_n - base), 32'd5);
        ks_ready = 1'b1;
        wait_done(base, "job2");
        check_stream(base, "job2");

        // timeout: core never signals done
        done_en = 1'b0;
        start_job(key_a, 32'h1, nonce_a);
        repeat (48) @(negedge clk);
        chk("to_start_uio", {24'b0, pin_uio}, 32'h02);
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (err !== 1'b0 || ks_valid !== 1'b0) bad++;
        end
        chk("to_early_errs", 32'(bad), 32'd0);
        @(negedge clk);
        chk("to_err_pulse", {31'b0, err}, 32'd1);
        chk("to_idle", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        chk("to_err_cleared", {31'b0, err}, 32'd0);
        chk("to_no_valid", {31'b0, ks_valid}, 32'd0);
        done_en = 1'b1;

        // reset during LOAD byte 20, then a fresh job
        start_job(key_b, 32'h1, nonce_a);
        repeat (20) @(negedge clk);
        chk("mid_byte20", {24'b0, pin_ui}, 32'hB4);
        rst = 1'b1;
        #1;
        chk("mid_rst_ui", {24'b0, pin_ui}, 32'd0);
        chk("mid_rst_uio", {24'b0, pin_uio}, 32'd0);
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_uio", {24'b0, pin_uio}, 32'd0);
        chk("post_rst_valid", {31'b0, ks_valid}, 32'd0);
        base = out_n; ack0 = ack_cnt;
        start_job(key_a, 32'h1, nonce_a);
        chk("restart_byte0", {24'b0, pin_ui}, 32'h00);
        chk("restart_uio", {24'b0, pin_uio}, 32'h01);
        @(negedge clk);
        chk("restart_byte1", {24'b0, pin_ui}, 32'h01);
        wait_done(base, "job3");
        check_stream(base, "job3");
        chk("job3_acks", 32'(ack_cnt - ack0), 32'd64);
        chk("strobe_overlap", 32'(multi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
